var_delay_line: RTL and testbench

- Runtime-programmable multi-bit delay line. It replaces fixed-tap shift delays in the video/TMDS path, for example channel deskew and sync/data alignment.
- Storage is a circular buffer with write/read pointers, so the delay can change while running.
- Tracks sample validity per stage.
- Masks output while the pipeline refills after a delay change.

---
 rtl/dlyline_pkg.sv | 30 +++
 rtl/dlyline_ram.sv | 61 ++++++
 rtl/var_delay_line.sv | 162 ++++++++++++++++
 tb/tb_var_delay_line.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dlyline_pkg.sv
// Shared types and helpers for the runtime-programmable delay line.
// Holds the refill state enum and the delay clamp helper.
package dlyline_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      REFILL = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] dly;
      logic        err;
   } clamp_t;

   // Map a requested delay into 1..max; flag anything outside that range.
   function automatic clamp_t clamp_dly(input logic [31:0] req, input logic [31:0] max);
      clamp_t r;
      r.dly = req;
      r.err = 1'b0;
      if (req == 32'd0) begin
         r.dly = 32'd1;
         r.err = 1'b1;
      end else if (req > max) begin
         r.dly = max;
         r.err = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dlyline_ram.sv
// Circular sample storage for var_delay_line: MAX_DLY entries of data plus a
// per-entry valid bit. Writes are synchronous and gated by ce; reads are
// asynchronous so the top can fetch the oldest entry before it is overwritten.
// The valid column is always cleared by reset so a fresh line never reports
// stale samples. The data column is cleared only when DLYLINE_RESET_DATA_EN is
// defined; otherwise it is left uninitialised so it can map onto LUTRAM/SRL.
module dlyline_ram #(
   parameter int WIDTH   = 8,
   parameter int MAX_DLY = 16,
   parameter int AW      = $clog2(MAX_DLY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid
);

   logic [WIDTH-1:0]   mem_data [MAX_DLY];
   logic [MAX_DLY-1:0] mem_valid;

`ifdef DLYLINE_RESET_DATA_EN
   // Data column as resettable flops so the output is never undefined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_DLY; i++) begin
            mem_data[i] <= '0;
         end
      end else if (ce) begin
         mem_data[wr_addr] <= wr_data;
      end
   end
`else
   // Data column without reset; contents are masked downstream until valid.
   always_ff @(posedge clk) begin
      if (ce) begin
         mem_data[wr_addr] <= wr_data;
      end
   end
`endif

   // Per-entry valid bits travel with the data and always reset to empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid <= '0;
      end else if (ce) begin
         mem_valid[wr_addr] <= wr_valid;
      end
   end

   // Asynchronous read of the selected tap.
   always_comb begin
      rd_data  = mem_data[rd_addr];
      rd_valid = mem_valid[rd_addr];
   end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line for the video/TMDS path (deskew, sync/data
// alignment). Samples go into a circular buffer; the tap is chosen from the
// write pointer and the delay in force, so the delay can change on the fly.
// After a delay change the output qualifier is masked for D ce-cycles while
// the new tap fills with samples taken at the new latency.
// Build option: DLYLINE_RESET_DATA_EN selects resettable storage; when it is
// undefined, data_o is forced to zero whenever valid_o is low.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal operation, valid_o follows the delayed qualifier
// REFILL | delay just changed; counting D ce-cycles, valid_o held low, busy=1
module var_delay_line
   import dlyline_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter int   MAX_DLY  = 16,
   parameter int   INIT_DLY = 4,
   localparam int  DLY_W    = $clog2(MAX_DLY + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   input  logic [DLY_W-1:0] dly_i,
   input  logic             dly_ld,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [DLY_W-1:0] dly_cur,
   output logic             busy,
   output logic             err_o
);

   localparam int PTR_W = $clog2(MAX_DLY);
   localparam int XW    = DLY_W + 1;

   state_t           state;
   state_t           state_nxt;
   logic [DLY_W-1:0] cnt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_addr;
   logic [XW-1:0]    rd_sum;
   logic [XW-1:0]    rd_idx;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [WIDTH-1:0] data_r;
   logic             valid_r;
   clamp_t           clamp_res;
   logic [DLY_W-1:0] dly_legal;
   logic             dly_bad;

   dlyline_ram #(
      .WIDTH   (WIDTH),
      .MAX_DLY (MAX_DLY),
      .AW      (PTR_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .wr_addr  (wr_ptr),
      .wr_data  (data_i),
      .wr_valid (valid_i),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   // Legalise the requested delay.
   always_comb begin
      clamp_res = clamp_dly(32'(dly_i), 32'(MAX_DLY));
      dly_legal = DLY_W'(clamp_res.dly);
      dly_bad   = clamp_res.err;
   end

   // Tap index (wr_ptr - (D-1)) mod MAX_DLY. Adding MAX_DLY first keeps the
   // intermediate positive; one extra bit holds values up to 2*MAX_DLY-1.
   always_comb begin
      rd_sum  = XW'(wr_ptr) + XW'(MAX_DLY) + XW'(1) - XW'(dly_cur);
      rd_idx  = (rd_sum >= XW'(MAX_DLY)) ? (rd_sum - XW'(MAX_DLY)) : rd_sum;
      rd_addr = PTR_W'(rd_idx);
   end

   // Write pointer advances and wraps on every ce cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (ce) begin
         wr_ptr <= (wr_ptr == PTR_W'(MAX_DLY - 1)) ? '0 : (wr_ptr + 1'b1);
      end
   end

   // Output stage register; D=1 bypasses the buffer to act as one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= '0;
         valid_r <= 1'b0;
      end else if (ce) begin
         if (dly_cur == DLY_W'(1)) begin
            data_r  <= data_i;
            valid_r <= valid_i;
         end else begin
            data_r  <= rd_data;
            valid_r <= rd_valid;
         end
      end
   end

   // Delay in force, refill counter and sticky error; loads ignore ce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_cur <= DLY_W'(INIT_DLY);
         cnt     <= '0;
         err_o   <= 1'b0;
      end else if (dly_ld) begin
         dly_cur <= dly_legal;
         cnt     <= dly_legal;
         err_o   <= err_o | dly_bad;
      end else if ((state == REFILL) && ce && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: any load (re)starts a refill, last ce count ends it.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (dly_ld) state_nxt = REFILL;
         end
         REFILL: begin
            if (dly_ld) begin
               state_nxt = REFILL;
            end else if (ce && (cnt == DLY_W'(1))) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // FSM outputs: mask the qualifier during refill, all from registers.
   always_comb begin
      busy    = (state == REFILL);
      valid_o = valid_r & ~busy;
`ifdef DLYLINE_RESET_DATA_EN
      data_o  = data_r;
`else
      data_o  = valid_o ? data_r : '0;
`endif
   end

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: directed scenarios followed by a
// random phase, all checked against a sample-history model of the line.
module tb_var_delay_line;

   localparam int WIDTH    = 8;
   localparam int MAX_DLY  = 16;
   localparam int INIT_DLY = 4;
   localparam int DLY_W    = $clog2(MAX_DLY + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ce;
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic [DLY_W-1:0] dly_i;
   logic             dly_ld;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic [DLY_W-1:0] dly_cur;
   logic             busy;
   logic             err_o;

   var_delay_line #(
      .WIDTH    (WIDTH),
      .MAX_DLY  (MAX_DLY),
      .INIT_DLY (INIT_DLY)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce      (ce),
      .data_i  (data_i),
      .valid_i (valid_i),
      .dly_i   (dly_i),
      .dly_ld  (dly_ld),
      .data_o  (data_o),
      .valid_o (valid_o),
      .dly_cur (dly_cur),
      .busy    (busy),
      .err_o   (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             v;
   } samp_t;

   // Reference model: history of samples taken on ce edges since reset,
   // the delay in force, refill cycles remaining and the sticky error.
   samp_t            hist[$];
   int               m_dly;
   int               m_rem;
   logic             m_err;
   logic             m_ov;
   logic [WIDTH-1:0] m_od;

   int n_tests = 0;
   int n_fail  = 0;
   int n_step  = 0;
   int ramp    = 1;

   task automatic model_reset();
      hist.delete();
      m_dly = INIT_DLY;
      m_rem = 0;
      m_err = 1'b0;
      m_ov  = 1'b0;
      m_od  = '0;
   endtask

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s step %0d: got %0h expected %0h", tag, n_step, got, exp);
      end
   endtask

   task automatic check_all();
      logic             exp_v;
      logic [WIDTH-1:0] exp_d;
      exp_v = m_ov && (m_rem == 0);
`ifdef DLYLINE_RESET_DATA_EN
      exp_d = m_od;
`else
      exp_d = exp_v ? m_od : '0;
`endif
      cmp("valid_o", 32'(valid_o), 32'(exp_v));
      cmp("data_o",  32'(data_o),  32'(exp_d));
      cmp("busy",    32'(busy),    32'(m_rem > 0));
      cmp("dly_cur", 32'(dly_cur), 32'(m_dly));
      cmp("err_o",   32'(err_o),   32'(m_err));
   endtask

   // One clock cycle: drive, clock, advance the model, check after the edge.
   task automatic step(input logic c, input logic v, input logic [WIDTH-1:0] d,
                       input logic ld, input logic [DLY_W-1:0] di);
      int idx;
      ce = c; valid_i = v; data_i = d; dly_ld = ld; dly_i = di;
      @(posedge clk);
      n_step++;
      if (c) begin
         hist.push_back('{d: d, v: v});
         if (hist.size() > MAX_DLY) void'(hist.pop_front());
         if (hist.size() >= m_dly) begin
            idx  = hist.size() - m_dly;
            m_ov = hist[idx].v;
            m_od = hist[idx].d;
         end else begin
            m_ov = 1'b0;
            m_od = '0;
         end
      end
      if (ld) begin
         if (di == 0) begin
            m_dly = 1;
            m_err = 1'b1;
         end else if (int'(di) > MAX_DLY) begin
            m_dly = MAX_DLY;
            m_err = 1'b1;
         end else begin
            m_dly = int'(di);
         end
         m_rem = m_dly;
      end else if (c && m_rem > 0) begin
         m_rem--;
      end
      #1;
      check_all();
   endtask

   task automatic ramp_steps(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, WIDTH'(ramp), 1'b0, '0);
         ramp++;
      end
   endtask

   task automatic load(input logic [DLY_W-1:0] di);
      step(1'b1, 1'b1, WIDTH'(ramp), 1'b1, di);
      ramp++;
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; valid_i = 1'b0; data_i = '0; dly_i = '0; dly_ld = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Initial fill at INIT_DLY with a ramp.
      ramp_steps(10);

      // Grow the delay to 9 and run through the refill.
      load(DLY_W'(9));
      ramp_steps(14);

      // Oversized request clamps to MAX_DLY, then zero clamps to 1.
      load(DLY_W'(20));
      ramp_steps(20);
      load(DLY_W'(0));
      ramp_steps(5);

      // D=3 with ce toggling.
      load(DLY_W'(3));
      ramp_steps(4);
      for (int i = 0; i < 16; i++) begin
         step((i % 2) == 0, 1'b1, WIDTH'(ramp), 1'b0, '0);
         ramp++;
      end

      // Load issued while ce is low.
      step(1'b0, 1'b1, WIDTH'(ramp), 1'b1, DLY_W'(6));
      ramp_steps(8);

      // Restart a refill part way through.
      load(DLY_W'(5));
      ramp_steps(2);
      load(DLY_W'(7));
      ramp_steps(10);

      // Asynchronous reset in the middle of a refill at D=12.
      load(DLY_W'(12));
      ramp_steps(4);
      dly_ld = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      ramp_steps(6);

      // Random traffic, including illegal delays and idle cycles.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(3) != 0, 1'($urandom_range(1)), WIDTH'($urandom),
              $urandom_range(24) == 0, DLY_W'($urandom_range(31)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
